// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared types and constants for the AES-128 round sequencer.
// A block is carried as four row-packed 32-bit words: word r holds state
// row r, with column 0 in the most significant byte.
package aes_seq_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int WORD_W         = 32;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } seq_state_t;

  // One 128-bit AES state, row-packed
  typedef struct packed {
    logic [WORD_W-1:0] row0;
    logic [WORD_W-1:0] row1;
    logic [WORD_W-1:0] row2;
    logic [WORD_W-1:0] row3;
  } block_t;

  // Builds a block from four row words
  function automatic block_t pack_block(input logic [WORD_W-1:0] w0,
                                        input logic [WORD_W-1:0] w1,
                                        input logic [WORD_W-1:0] w2,
                                        input logic [WORD_W-1:0] w3);
    block_t b;
    b.row0 = w0;
    b.row1 = w1;
    b.row2 = w2;
    b.row3 = w3;
    return b;
  endfunction

  // AddRoundKey on row-packed blocks
  function automatic block_t block_xor(input block_t a, input block_t b);
    block_t r;
    r.row0 = a.row0 ^ b.row0;
    r.row1 = a.row1 ^ b.row1;
    r.row2 = a.row2 ^ b.row2;
    r.row3 = a.row3 ^ b.row3;
    return r;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: bundles the plaintext/ciphertext handshakes, the
// round-key store lookup and the round datapath connection of the sequencer.
// The master modport is the sequencer's view; slave is its surroundings.
interface aes_round_sequencer_if #(
  parameter int ROUND_W = 4
);
  import aes_seq_pkg::*;

  // Plaintext request
  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_d0;
  logic [WORD_W-1:0]  in_d1;
  logic [WORD_W-1:0]  in_d2;
  logic [WORD_W-1:0]  in_d3;

  // Round-key store lookup (combinational)
  logic [ROUND_W-1:0] rk_round;
  logic [WORD_W-1:0]  rk_q0;
  logic [WORD_W-1:0]  rk_q1;
  logic [WORD_W-1:0]  rk_q2;
  logic [WORD_W-1:0]  rk_q3;

  // Single-round datapath
  logic [WORD_W-1:0]  rnd_a;
  logic [WORD_W-1:0]  rnd_b;
  logic [WORD_W-1:0]  rnd_c;
  logic [WORD_W-1:0]  rnd_d;
  logic [ROUND_W-1:0] rnd_count;
  logic               rnd_key_flag;
  logic [WORD_W-1:0]  rnd_q1;
  logic [WORD_W-1:0]  rnd_q2;
  logic [WORD_W-1:0]  rnd_q3;
  logic [WORD_W-1:0]  rnd_q4;
  logic [WORD_W-1:0]  rnd_x;
  logic [WORD_W-1:0]  rnd_y;
  logic [WORD_W-1:0]  rnd_z;
  logic [WORD_W-1:0]  rnd_w;

  // Ciphertext response and status
  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  out_d0;
  logic [WORD_W-1:0]  out_d1;
  logic [WORD_W-1:0]  out_d2;
  logic [WORD_W-1:0]  out_d3;
  logic               busy;

  modport master (
    input  in_valid, in_d0, in_d1, in_d2, in_d3,
    output in_ready,
    output rk_round,
    input  rk_q0, rk_q1, rk_q2, rk_q3,
    output rnd_a, rnd_b, rnd_c, rnd_d, rnd_count, rnd_key_flag,
    output rnd_q1, rnd_q2, rnd_q3, rnd_q4,
    input  rnd_x, rnd_y, rnd_z, rnd_w,
    output out_valid, out_d0, out_d1, out_d2, out_d3,
    input  out_ready,
    output busy
  );

  modport slave (
    output in_valid, in_d0, in_d1, in_d2, in_d3,
    input  in_ready,
    input  rk_round,
    output rk_q0, rk_q1, rk_q2, rk_q3,
    input  rnd_a, rnd_b, rnd_c, rnd_d, rnd_count, rnd_key_flag,
    input  rnd_q1, rnd_q2, rnd_q3, rnd_q4,
    output rnd_x, rnd_y, rnd_z, rnd_w,
    input  out_valid, out_d0, out_d1, out_d2, out_d3,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: walks an external single-round AES datapath through
// a full AES-128 encryption of one block. The initial AddRoundKey is done
// here on accept; every following round takes an ISSUE cycle (datapath
// samples the state) and a CAPTURE cycle (datapath result is written back).
// The round-key store is external and indexed by rk_round.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int ROUND_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_round_sequencer_if.master bus
);

  localparam logic [ROUND_W-1:0] FIRST_ROUND = ROUND_W'(1);
  localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NUM_ROUNDS);

  seq_state_t         state;
  seq_state_t         state_next;
  block_t             state_reg;
  logic [ROUND_W-1:0] round;

  block_t             in_block;
  block_t             key_block;
  block_t             rnd_block;
  logic               accept;
  logic               deliver;
  logic               last_round;

  logic               in_ready_c;
  logic               busy_c;
  logic               out_valid_c;
  logic               rnd_key_flag_c;
  logic [ROUND_W-1:0] rk_round_c;
  logic [ROUND_W-1:0] rnd_count_c;
  block_t             rnd_state_c;
  block_t             rnd_key_c;
  block_t             out_block_c;

  assign in_block   = pack_block(bus.in_d0, bus.in_d1, bus.in_d2, bus.in_d3);
  assign key_block  = pack_block(bus.rk_q0, bus.rk_q1, bus.rk_q2, bus.rk_q3);
  assign rnd_block  = pack_block(bus.rnd_x, bus.rnd_y, bus.rnd_z, bus.rnd_w);

  // in_ready is only ever high in IDLE, so the handshake reduces to this
  assign accept     = (state == IDLE) && bus.in_valid;
  assign deliver    = (state == DONE) && bus.out_ready;
  // Compare with >= so a corrupted counter still terminates the block
  assign last_round = (round >= LAST_ROUND);

  // State register; reset aborts any block in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and all datapath/handshake outputs
  always_comb begin
    state_next     = state;
    in_ready_c     = 1'b0;
    busy_c         = 1'b1;
    out_valid_c    = 1'b0;
    rnd_key_flag_c = 1'b1;
    rk_round_c     = '0;
    rnd_count_c    = '0;
    rnd_state_c    = '0;
    rnd_key_c      = '0;
    out_block_c    = '0;

    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (accept) begin
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        rk_round_c     = round;
        rnd_count_c    = round;
        rnd_key_flag_c = 1'b0;
        rnd_state_c    = state_reg;
        rnd_key_c      = key_block;
        state_next     = CAPTURE;
      end

      CAPTURE: begin
        rk_round_c     = round;
        rnd_count_c    = round;
        rnd_key_flag_c = 1'b0;
        rnd_state_c    = state_reg;
        rnd_key_c      = key_block;
        state_next     = last_round ? DONE : ISSUE;
      end

      DONE: begin
        out_valid_c = 1'b1;
        out_block_c = state_reg;
        if (deliver) begin
          state_next = IDLE;
        end
      end

      default: begin
        busy_c     = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Block state and round counter: whitening on accept, write-back on capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      round     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_reg <= block_xor(in_block, key_block);
            round     <= FIRST_ROUND;
          end
        end
        CAPTURE: begin
          state_reg <= rnd_block;
          if (!last_round) begin
            round <= round + 1'b1;
          end
        end
        DONE: begin
          if (deliver) begin
            round <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.busy         = busy_c;
  assign bus.rk_round     = rk_round_c;
  assign bus.rnd_count    = rnd_count_c;
  assign bus.rnd_key_flag = rnd_key_flag_c;
  assign bus.rnd_a        = rnd_state_c.row0;
  assign bus.rnd_b        = rnd_state_c.row1;
  assign bus.rnd_c        = rnd_state_c.row2;
  assign bus.rnd_d        = rnd_state_c.row3;
  assign bus.rnd_q1       = rnd_key_c.row0;
  assign bus.rnd_q2       = rnd_key_c.row1;
  assign bus.rnd_q3       = rnd_key_c.row2;
  assign bus.rnd_q4       = rnd_key_c.row3;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_d0       = out_block_c.row0;
  assign bus.out_d1       = out_block_c.row1;
  assign bus.out_d2       = out_block_c.row2;
  assign bus.out_d3       = out_block_c.row3;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: surrounds the sequencer with a behavioural key
// store and single-round AES datapath, and scores every ciphertext against
// a full AES-128 reference pushed at accept time.
module tb_aes_round_sequencer;

  localparam int NR = 10;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h004488cc_115599dd_2266aaee_3377bbff;
  localparam logic [127:0] C1_CT  = 128'h696ad870_c47bcdb4_e004b7c5_d830805a;

  logic clk;
  logic rst;

  int num_checks = 0;
  int num_fails  = 0;
  int unsigned cycle_cnt = 0;

  logic [127:0] rk_tab [0:NR];
  logic [127:0] exp_q [$];
  bit           in_flight = 0;
  int           cyc = 0;

  aes_round_sequencer_if #(.ROUND_W(4)) bus ();

  aes_round_sequencer #(
    .NUM_ROUNDS(NR),
    .ROUND_W   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock and a cycle counter for throughput measurement
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // ---------------- AES reference helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (bits 1..7 of the exponent are set)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] res, base;
    res = 8'h01; base = x;
    for (int e = 0; e < 8; e++) begin
      if (e != 0) res = gmul(res, base);
      base = gmul(base, base);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    logic [63:0]  t;
    for (int j = 0; j < 4; j++) begin
      t = {s[127-32*j -: 32], s[127-32*j -: 32]};
      r[127-32*j -: 32] = t[63-8*j -: 32];
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*c -: 8];
      a1 = s[95-8*c  -: 8];
      a2 = s[63-8*c  -: 8];
      a3 = s[31-8*c  -: 8];
      r[127-8*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[95-8*c  -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[63-8*c  -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[31-8*c  -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

  function automatic logic [127:0] round_core(input logic [127:0] s, input bit last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s));
    if (!last) t = mix_columns(t);
    return t;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= NR; r++) s = round_core(s, r == NR) ^ rk_tab[r];
    return s;
  endfunction

  // Standard AES-128 key expansion, stored row-packed per round
  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t[31:24] = t[31:24] ^ rcon;
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      for (int j = 0; j < 4; j++)
        for (int c = 0; c < 4; c++)
          rk_tab[r][127-32*j-8*c -: 8] = w[4*r+c][31-8*j -: 8];
  endtask

  // ---------------- Environment models ----------------
  logic [127:0] rk_sel;
  logic [127:0] dp_in;
  logic [3:0]   dp_count;
  logic         dp_flag;
  logic [127:0] dp_out;

  // Key store: combinational lookup by rk_round
  assign rk_sel = (bus.rk_round <= 4'(NR)) ? rk_tab[bus.rk_round] : 128'd0;
  assign {bus.rk_q0, bus.rk_q1, bus.rk_q2, bus.rk_q3} = rk_sel;

  // Round datapath: registers state/count/flag, adds the live round key
  always @(posedge clk) begin
    dp_in    <= {bus.rnd_a, bus.rnd_b, bus.rnd_c, bus.rnd_d};
    dp_count <= bus.rnd_count;
    dp_flag  <= bus.rnd_key_flag;
  end
  assign dp_out = round_core(dp_in, (dp_count == 4'(NR)) && !dp_flag) ^
                  {bus.rnd_q1, bus.rnd_q2, bus.rnd_q3, bus.rnd_q4};
  assign {bus.rnd_x, bus.rnd_y, bus.rnd_z, bus.rnd_w} = dp_out;

  // ---------------- Checking ----------------
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Scoreboard and per-cycle sequencing monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [3:0]   exp_round;
    logic [127:0] exp_ct;
    if (in_flight) begin
      cyc = cyc + 1;
      if (cyc <= 2*NR) begin
        exp_round = 4'((cyc + 1) / 2);
        checkOutput("seq_rnd_count", 128'(bus.rnd_count), 128'(exp_round));
        checkOutput("seq_rk_round", 128'(bus.rk_round), 128'(exp_round));
        checkOutput("seq_key_flag", 128'(bus.rnd_key_flag), 128'd0);
        checkOutput("seq_rnd_q", {bus.rnd_q1, bus.rnd_q2, bus.rnd_q3, bus.rnd_q4},
                    rk_tab[exp_round]);
        checkOutput("seq_busy", 128'(bus.busy), 128'd1);
        checkOutput("seq_early_out_valid", 128'(bus.out_valid), 128'd0);
      end else begin
        checkOutput("latency_out_valid", 128'(bus.out_valid), 128'd1);
        in_flight = 0;
      end
    end
    if (rst) begin
      exp_q.delete();
      in_flight = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(aes_ref({bus.in_d0, bus.in_d1, bus.in_d2, bus.in_d3}));
        in_flight = 1;
        cyc = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput("sb_has_entry", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          exp_ct = exp_q.pop_front();
          checkOutput("sb_ciphertext", {bus.out_d0, bus.out_d1, bus.out_d2, bus.out_d3},
                      exp_ct);
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  // Presents one plaintext and holds it until the sequencer takes it
  task automatic applyStimulus(input logic [127:0] pt);
    bit accepted;
    accepted = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    {bus.in_d0, bus.in_d1, bus.in_d2, bus.in_d3} = pt;
    for (int i = 0; i < 80 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) accepted = 1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("accept_seen", 128'(accepted), 128'd1);
  endtask

  task automatic wait_output(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    checkOutput(tag, 128'(seen), 128'd1);
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Hard stop if anything above stops making progress
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] held;
    logic [127:0] pt;
    int unsigned  last_accept;
    bit           seen;

    expand_key(C1_KEY);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    {bus.in_d0, bus.in_d1, bus.in_d2, bus.in_d3} = '0;
    last_accept   = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("rst_busy", 128'(bus.busy), 128'd0);
    checkOutput("rst_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("rst_key_flag", 128'(bus.rnd_key_flag), 128'd1);
    checkOutput("rst_rk_round", 128'(bus.rk_round), 128'd0);
    checkOutput("rst_rnd_count", 128'(bus.rnd_count), 128'd0);
    checkOutput("rst_out_d", {bus.out_d0, bus.out_d1, bus.out_d2, bus.out_d3}, 128'd0);
    checkOutput("rst_rnd_state", {bus.rnd_a, bus.rnd_b, bus.rnd_c, bus.rnd_d}, 128'd0);
    checkOutput("rst_rnd_q", {bus.rnd_q1, bus.rnd_q2, bus.rnd_q3, bus.rnd_q4}, 128'd0);

    // FIPS-197 C.1 known answer
    bus.out_ready = 1'b1;
    applyStimulus(C1_PT);
    wait_output("c1_out_valid_seen");
    checkOutput("c1_ciphertext", {bus.out_d0, bus.out_d1, bus.out_d2, bus.out_d3}, C1_CT);

    // Output backpressure with ignored in_valid
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    pt = rand_block();
    applyStimulus(pt);
    wait_output("bp_out_valid_seen");
    held = {bus.out_d0, bus.out_d1, bus.out_d2, bus.out_d3};
    checkOutput("bp_ciphertext", held, aes_ref(pt));
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    {bus.in_d0, bus.in_d1, bus.in_d2, bus.in_d3} = rand_block();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput("bp_out_d_stable", {bus.out_d0, bus.out_d1, bus.out_d2, bus.out_d3}, held);
      checkOutput("bp_out_valid", 128'(bus.out_valid), 128'd1);
      checkOutput("bp_in_ready", 128'(bus.in_ready), 128'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    pt = rand_block();
    {bus.in_d0, bus.in_d1, bus.in_d2, bus.in_d3} = pt;
    @(negedge clk);
    checkOutput("bp_release_valid", 128'(bus.out_valid), 128'd1);
    @(negedge clk);
    checkOutput("bp_idle_after_release", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_output("bp_second_out_valid_seen");

    // Reset in the CAPTURE cycle of round 5, then a fresh block
    pt = rand_block();
    applyStimulus(pt);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rnd_count", 128'(bus.rnd_count), 128'd5);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("mid_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("mid_busy", 128'(bus.busy), 128'd0);
    checkOutput("mid_key_flag", 128'(bus.rnd_key_flag), 128'd1);
    applyStimulus(rand_block());
    wait_output("mid_fresh_out_valid_seen");

    // in_valid held high: one accept per 22 cycles
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    {bus.in_d0, bus.in_d1, bus.in_d2, bus.in_d3} = rand_block();
    for (int n = 0; n < 4; n++) begin
      seen = 0;
      for (int i = 0; i < 80 && !seen; i++) begin
        @(negedge clk);
        if (bus.in_ready) seen = 1;
      end
      checkOutput("hold_accept_seen", 128'(seen), 128'd1);
      if (n > 0) checkOutput("hold_accept_period", 128'(cycle_cnt - last_accept), 128'd22);
      last_accept = cycle_cnt;
      @(posedge clk); #1;
      if (n < 3) {bus.in_d0, bus.in_d1, bus.in_d2, bus.in_d3} = rand_block();
      else bus.in_valid = 1'b0;
    end
    wait_output("hold_last_out_valid_seen");

    // rst and in_valid together: reset wins
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    {bus.in_d0, bus.in_d1, bus.in_d2, bus.in_d3} = rand_block();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstv_in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("rstv_busy", 128'(bus.busy), 128'd0);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
